// File: rtl/xor_chk_pkg.sv
// Shared types and constants for the XOR response checker.
package xor_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/xor_resp_misr.sv
// Multiple-input signature register compacting the result stream.
module xor_resp_misr
    import xor_chk_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] fb;

    assign fb = sig[WIDTH-1] ? WIDTH'(POLY) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= WIDTH'(SEED);
        end else if (clear) begin
            sig <= WIDTH'(SEED);
        end else if (en) begin
            sig <= {sig[WIDTH-2:0], 1'b0} ^ fb ^ d;
        end
    end

endmodule

// File: rtl/xor_resp_checker.sv
// Collects a/b/y samples, recomputes a^b and reports a pass/fail verdict.
// Define XOR_CHK_MISR_EN to build the result signature register.
module xor_resp_checker
    import xor_chk_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_y,
    output logic [WIDTH-1:0] signature
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_n;
    logic             accept;
    logic             mismatch;
    logic [CNT_W-1:0] scnt_nxt;
    logic [CNT_W-1:0] ecnt_nxt;

    // A sample coincident with start belongs to the run being abandoned.
    assign accept   = (state == RUN) && in_valid && !start;
    assign mismatch = y != (a ^ b);

    assign scnt_nxt = (sample_cnt == CNT_MAX) ? sample_cnt
                    : sample_cnt + CNT_W'(1);
    assign ecnt_nxt = (mismatch && err_cnt != CNT_MAX) ? err_cnt + CNT_W'(1)
                    : err_cnt;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (1'b1)
            start:              state_n = RUN;
            accept && in_last:  state_n = DONE;
            default:            state_n = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass          <= 1'b0;
            sample_cnt    <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_y   <= '0;
        end else begin
            unique case (1'b1)
                start: begin
                    pass          <= 1'b0;
                    sample_cnt    <= '0;
                    err_cnt       <= '0;
                    first_err_idx <= '0;
                    first_err_y   <= '0;
                end
                accept: begin
                    sample_cnt <= scnt_nxt;
                    err_cnt    <= ecnt_nxt;
                    // err_cnt saturates, so zero means no mismatch seen yet.
                    if (mismatch && err_cnt == '0) begin
                        first_err_idx <= sample_cnt;
                        first_err_y   <= y;
                    end
                    if (in_last) begin
                        pass <= (scnt_nxt != '0) && (ecnt_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef XOR_CHK_MISR_EN
    xor_resp_misr #(
        .WIDTH (WIDTH)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .en    (accept),
        .d     (y),
        .sig   (signature)
    );
`else
    assign signature = '0;
`endif

endmodule
